// File: rtl/prog_loader.sv
// prog_loader: writer side of the program memory.
// Accepts a valid/ready word stream and writes it to consecutive addresses
// (modulo 2**AWIDTH) through the memory load/addr/d port. It owns the memory
// port while busy and pulses done for one cycle when the load finishes.
// Optional feature macro: PROG_LOADER_VERIFY_EN. When defined, every written
// word is read back through mem_q and compared. Any mismatch sets the sticky
// err flag. Throughput in that build is 1 word per 3 clocks.
module prog_loader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   count,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              mem_load,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH:0]   words_wr,
    output logic              err
);

    // Largest meaningful word count. Larger requests are clamped so a load
    // never writes any address twice.
    localparam logic [AWIDTH:0] WORDS_CNT = WORDS[AWIDTH:0];

`ifdef PROG_LOADER_VERIFY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_RDBK, ST_CHK, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;
`endif

    state_t              state_reg, state_next;
    logic [AWIDTH-1:0]   addr_reg, addr_next;
    logic [AWIDTH:0]     remaining_reg, remaining_next;
    logic [AWIDTH:0]     words_wr_reg, words_wr_next;
    logic                handshake;

`ifdef PROG_LOADER_VERIFY_EN
    logic [DWIDTH-1:0]   chk_data_reg, chk_data_next;
    logic                err_reg, err_next;
`else
    // Without read-back the memory output is not used.
    logic                unused_mem_q;
    assign unused_mem_q = ^mem_q;
`endif

    assign handshake = in_valid && (state_reg == ST_WRITE);

    // Next-state, datapath updates and memory-port outputs.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        words_wr_next  = words_wr_reg;
        in_ready       = 1'b0;
        mem_load       = 1'b0;
        mem_d          = '0;
        done           = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
        chk_data_next  = chk_data_reg;
        err_next       = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    addr_next      = base_addr;
                    remaining_next = (count > WORDS_CNT) ? WORDS_CNT : count;
                    words_wr_next  = '0;
`ifdef PROG_LOADER_VERIFY_EN
                    err_next       = 1'b0;
`endif
                    state_next     = (count == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                in_ready = 1'b1;
                if (handshake) begin
                    mem_load      = 1'b1;
                    mem_d         = in_data;
                    words_wr_next = words_wr_reg + 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
                    // The address advances only after the word has been checked.
                    chk_data_next = in_data;
                    state_next    = ST_RDBK;
`else
                    addr_next      = addr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    state_next     = (remaining_reg == 1) ? ST_DONE : ST_WRITE;
`endif
                end
            end
`ifdef PROG_LOADER_VERIFY_EN
            ST_RDBK: begin
                // mem_addr still points at the word just written. The memory
                // registers it onto mem_q at the end of this cycle.
                state_next = ST_CHK;
            end
            ST_CHK: begin
                if (mem_q != chk_data_reg) begin
                    err_next = 1'b1;
                end
                addr_next      = addr_reg + 1'b1;
                remaining_next = remaining_reg - 1'b1;
                state_next     = (remaining_reg == 1) ? ST_DONE : ST_WRITE;
            end
`endif
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers. A reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            remaining_reg <= '0;
            words_wr_reg  <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            chk_data_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            words_wr_reg  <= words_wr_next;
`ifdef PROG_LOADER_VERIFY_EN
            chk_data_reg  <= chk_data_next;
            err_reg       <= err_next;
`endif
        end
    end

    assign mem_addr = addr_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign words_wr = words_wr_reg;
`ifdef PROG_LOADER_VERIFY_EN
    assign err      = err_reg;
`else
    assign err      = 1'b0;
`endif

endmodule
